// File: rtl/branch_resolve_unit_if.sv
// branch_resolve_unit_if: redirect request/ack handshake between execute and fetch.
interface branch_resolve_unit_if #(
    parameter int WIDTH = 32
);
    logic             redirect_valid;
    logic [WIDTH-1:0] redirect_pc;
    logic             redirect_ack;

    modport master (output redirect_valid, output redirect_pc, input redirect_ack);
    modport slave  (input redirect_valid, input redirect_pc, output redirect_ack);
endinterface

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: resolves bne/blt in execute, redirects fetch, squashes wrong path
// and keeps saturating branch/taken statistics.
module branch_resolve_unit #(
    parameter int WIDTH        = 32,
    parameter int IMM_W        = 17,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stall_i,
    input  logic                    dx_valid_i,
    input  logic                    bne_signal_i,
    input  logic                    blt_signal_i,
    input  logic [WIDTH-1:0]        dx_pc_plus1_i,
    input  logic [WIDTH-1:0]        branch_n_i,
    input  logic [WIDTH-1:0]        data_s2_i,
    input  logic [WIDTH-1:0]        data_s1_i,
    branch_resolve_unit_if.master   redir,
    output logic                    flush_o,
    output logic                    busy_o,
    output logic [CNT_W-1:0]        branch_count_o,
    output logic [CNT_W-1:0]        taken_count_o
);
    localparam int FC_W = FLUSH_CYCLES > 1 ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, REDIRECT, SQUASH} state_t;

    state_t            state_q, state_d;
    logic [FC_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0]  bc_q, bc_d, tc_q, tc_d;
    logic              cap, taken;
    logic [WIDTH-1:0]  target;
    logic              unused_n;

    assign unused_n = ^branch_n_i[WIDTH-1:IMM_W];
    assign cap      = (state_q == IDLE) & dx_valid_i & ~stall_i & (bne_signal_i | blt_signal_i);
    // bne wins when decode raises both flags
    assign taken    = bne_signal_i ? (data_s2_i != data_s1_i)
                                   : ($signed(data_s2_i) < $signed(data_s1_i));
    assign target   = dx_pc_plus1_i + {{(WIDTH-IMM_W){branch_n_i[IMM_W-1]}}, branch_n_i[IMM_W-1:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        bc_d    = (cap && bc_q != '1) ? bc_q + 1'b1 : bc_q;
        tc_d    = (cap && taken && tc_q != '1) ? tc_q + 1'b1 : tc_q;
        unique case (state_q)
            IDLE: if (cap && taken) begin
                state_d = REDIRECT;
                pc_d    = target;
            end
            REDIRECT: if (redir.redirect_ack) begin
                state_d = SQUASH;
                cnt_d   = FC_W'(FLUSH_CYCLES - 1);
            end
            SQUASH: if (cnt_q == '0) state_d = IDLE;
                    else cnt_d = cnt_q - 1'b1;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pc_q    <= '0;
            bc_q    <= '0;
            tc_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            bc_q    <= bc_d;
            tc_q    <= tc_d;
        end
    end

    assign redir.redirect_valid = (state_q == REDIRECT);
    assign redir.redirect_pc    = pc_q;
    assign flush_o              = (state_q != IDLE);
    assign busy_o               = (state_q != IDLE);
    assign branch_count_o       = bc_q;
    assign taken_count_o        = tc_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed vectors for branch_resolve_unit, plus a CNT_W=2
// instance fed the same stimulus for saturation.
module tb_branch_resolve_unit;
    logic        clk = 0;
    logic        rst, stall, dxv, bne, blt, ack;
    logic [31:0] pc1, n, s2, s1;
    logic        flush, busy, flush_s, busy_s;
    logic [15:0] bc, tc;
    logic [1:0]  bc_s, tc_s;
    int          n_cmp = 0, n_bad = 0;

    branch_resolve_unit_if #(.WIDTH(32)) rif ();
    branch_resolve_unit_if #(.WIDTH(32)) rif_s ();
    assign rif.redirect_ack   = ack;
    assign rif_s.redirect_ack = ack;

    branch_resolve_unit dut (
        .clk(clk), .rst(rst), .stall_i(stall), .dx_valid_i(dxv), .bne_signal_i(bne),
        .blt_signal_i(blt), .dx_pc_plus1_i(pc1), .branch_n_i(n), .data_s2_i(s2),
        .data_s1_i(s1), .redir(rif.master), .flush_o(flush), .busy_o(busy),
        .branch_count_o(bc), .taken_count_o(tc));

    branch_resolve_unit #(.CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .stall_i(stall), .dx_valid_i(dxv), .bne_signal_i(bne),
        .blt_signal_i(blt), .dx_pc_plus1_i(pc1), .branch_n_i(n), .data_s2_i(s2),
        .data_s1_i(s1), .redir(rif_s.master), .flush_o(flush_s), .busy_o(busy_s),
        .branch_count_o(bc_s), .taken_count_o(tc_s));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic br(input logic b_ne, input logic b_lt, input logic [31:0] a2,
                      input logic [31:0] a1, input logic [31:0] p, input logic [31:0] imm);
        dxv = 1; bne = b_ne; blt = b_lt; s2 = a2; s1 = a1; pc1 = p; n = imm;
        step();
        dxv = 0; bne = 0; blt = 0;
    endtask

    task automatic handshake();
        ack = 1;
        step();
        ack = 0;
        step();
        step();
    endtask

    initial begin
        rst = 1; stall = 0; dxv = 0; bne = 0; blt = 0; ack = 0;
        pc1 = 0; n = 0; s2 = 0; s1 = 0;
        step(); step();
        rst = 0;
        chk("rst_valid", 32'(rif.redirect_valid), 0);
        chk("rst_flush", 32'(flush), 0);
        chk("rst_busy",  32'(busy), 0);
        chk("rst_pc",    rif.redirect_pc, 0);
        chk("rst_bc",    32'(bc), 0);
        chk("rst_tc",    32'(tc), 0);

        br(1, 0, 32'd5, 32'd7, 32'h10, 32'h4);
        chk("bne_valid", 32'(rif.redirect_valid), 1);
        chk("bne_pc",    rif.redirect_pc, 32'h14);
        chk("bne_flush1", 32'(flush), 1);
        chk("bne_bc",    32'(bc), 1);
        chk("bne_tc",    32'(tc), 1);
        ack = 1;
        step();
        ack = 0;
        chk("sq_valid",  32'(rif.redirect_valid), 0);
        chk("sq_flush2", 32'(flush), 1);
        step();
        chk("sq_flush3", 32'(flush), 1);
        step();
        chk("sq_done_flush", 32'(flush), 0);
        chk("sq_done_busy",  32'(busy), 0);

        br(0, 1, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h1FFFF);
        chk("blt_valid", 32'(rif.redirect_valid), 1);
        chk("blt_pc",    rif.redirect_pc, 32'h1F);
        chk("blt_tc",    32'(tc), 2);
        handshake();
        chk("blt_idle",  32'(busy), 0);

        br(0, 1, 32'd1, 32'hFFFF_FFFF, 32'h20, 32'h1FFFF);
        chk("bltnt_flush", 32'(flush), 0);
        chk("bltnt_valid", 32'(rif.redirect_valid), 0);
        chk("bltnt_bc",    32'(bc), 3);
        chk("bltnt_tc",    32'(tc), 2);

        br(1, 0, 32'd1, 32'd2, 32'h100, 32'h10);
        for (int i = 0; i < 4; i++) begin
            dxv = i[0]; bne = 1; blt = i[1]; s2 = 32'd9; s1 = 32'd3;
            step();
            chk("hold_valid", 32'(rif.redirect_valid), 1);
            chk("hold_flush", 32'(flush), 1);
            chk("hold_pc",    rif.redirect_pc, 32'h110);
        end
        dxv = 0; bne = 0; blt = 0;
        chk("hold_bc", 32'(bc), 4);
        chk("hold_tc", 32'(tc), 3);
        handshake();

        ack = 1;
        step();
        ack = 0;
        chk("stray_ack_busy", 32'(busy), 0);

        br(1, 0, 32'd0, 32'd1, 32'hFFFF_FFFF, 32'h2);
        chk("wrap_pc", rif.redirect_pc, 32'h1);
        handshake();

        stall = 1;
        br(1, 0, 32'd0, 32'd1, 32'h50, 32'h2);
        stall = 0;
        chk("stall_valid", 32'(rif.redirect_valid), 0);
        chk("stall_busy",  32'(busy), 0);
        chk("stall_bc",    32'(bc), 5);

        br(1, 1, 32'd5, 32'd3, 32'h40, 32'h8);
        chk("both_pc", rif.redirect_pc, 32'h48);
        chk("both_tc", 32'(tc), 5);
        ack = 1;
        step();
        ack = 0;
        chk("pre_rst_flush", 32'(flush), 1);
        rst = 1;
        step();
        rst = 0;
        chk("mid_rst_flush", 32'(flush), 0);
        chk("mid_rst_valid", 32'(rif.redirect_valid), 0);
        chk("mid_rst_busy",  32'(busy), 0);
        chk("mid_rst_bc",    32'(bc), 0);
        chk("mid_rst_pc",    rif.redirect_pc, 0);

        for (int i = 0; i < 5; i++) begin
            br(1, 0, 32'd1, 32'd2, 32'h200, 32'h4);
            handshake();
        end
        chk("sat_bc_small", 32'(bc_s), 3);
        chk("sat_tc_small", 32'(tc_s), 3);
        chk("sat_bc_big",   32'(bc), 5);
        chk("sat_tc_big",   32'(tc), 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
